led_zone_shifter: RTL
=====================

# led_zone_shifter

Serialises one frame of 360 local-dimming zone gray levels from the zone buffer into the MiniLED driver chain. Each zone value gets a global brightness scale. The block generates the DCLK/SDI/LE shift protocol and the 4-line scan enables. It sits directly downstream of `buffer_360`, using that block's read port `rd_buf_en` / `array_map` / `gray_data`, and drives the MiniLED panel pins in the 50 MHz domain.

## Interface
Parameters:
- `ZONES`, 90: zones per scan line; addresses span `SCANS*ZONES` = 360.
- `SCANS`, 4: scan lines.
- `DEAD`, 16: blanking cycles between scan lines, during which all scan enables are low.

Ports (one clock; reset is synchronous and active-high):
- `I_clk`, input, 1: 50 MHz system clock.
- `I_rst`, input, 1: synchronous, active-high reset.
- `I_frame_start`, input, 1: single-cycle pulse meaning a new zone frame is ready in the buffer.
- `I_brightness`, input, 8: global brightness; sampled once per frame when the frame starts.
- `O_rd_buf_en`, output, 1: buffer read strobe.
- `O_array_map`, output, 9: buffer read address.
- `I_gray_data`, input, 8: buffer read data, valid exactly one cycle after `O_rd_buf_en`.
- `O_DCLK`, output, 1: shift clock, I_clk/4 (12.5 MHz) while shifting.
- `O_SDI`, output, 1: serial data, MSB first.
- `O_LE`, output, 1: latch enable.
- `O_scan`, output, 4: one-hot scan-line enable, active-high.
- `O_busy`, output, 1: frame in progress.

## Operation
- **Reset.** All outputs are 0. FSM goes to IDLE, counters clear, the pending flag clears. Reset mid-frame aborts immediately; no LE pulse is issued.
- **States.** IDLE → FETCH → LOAD → SHIFT → (next zone: FETCH | scan done: LATCH) → DEAD → (next scan: FETCH | last scan: IDLE).
- **IDLE.** On `I_frame_start` (or a pending flag): capture `I_brightness`, clear the pending flag, set scan=0 and zone=ZONES-1, go to FETCH.
- **FETCH** (1 cycle).
  - `O_rd_buf_en`=1.
  - `O_array_map` = scan*ZONES + zone, a 9-bit unsigned product/sum; the maximum value is 359.
- **LOAD** (1 cycle).
  - Compute scaled = (`I_gray_data` * (bright+1)) >> 8, with a 17-bit product and the low 8 bits of the shifted result kept.
  - bright=255 gives identity; bright=0 gives 0.
  - Load `scaled` into an 8-bit shift register.
- **SHIFT** (32 cycles, 8 bits × 4 phases).
  - Phases 0–1: DCLK=0. SDI is updated to the current bit at the start of phase 0.
  - Phases 2–3: DCLK=1.
  - Bit order is MSB first.
  - Zones go out in descending order, ZONES-1 down to 0, so zone 0 is shifted last.
- **LATCH** (4 cycles).
  - LE=1, DCLK=0, SDI=0.
- **DEAD** (DEAD cycles).
  - `O_scan`=0.
  - At DEAD exit, `O_scan` = one-hot(scan), which holds until the next DEAD.
  - Then scan++ and zone=ZONES-1. After scan SCANS-1, go to IDLE.
- **Scan enable.** Line `s` is displayed while line `s+1` data shifts. After the frame, line SCANS-1 stays enabled in IDLE until the next frame's first DEAD.
- **Frame start while busy.** `I_frame_start` while not in IDLE sets the pending flag; multiple pulses collapse into one. A pulse in the same cycle as the return to IDLE also sets pending. `I_brightness` is not resampled mid-frame.
- **Busy.** `O_busy`=1 in every state except IDLE.

## Timing
- **Start.** `I_frame_start` high at edge k → FETCH in cycle k+1, with `O_rd_buf_en`=1, `O_array_map`=89, `O_busy`=1.
- **Per zone:** 34 cycles.
- **Per scan:** 90×34 + 4 + 16 = 3080 cycles.
- **Per frame:** 12320 cycles. The return to IDLE is 12320 cycles after the FETCH cycle of zone 89, scan 0.
- **Restart.** With pending set, the next frame's FETCH follows 1 cycle after IDLE.
- **Clocking.** DCLK is 0 outside SHIFT. SDI is stable for ≥2 I_clk before each DCLK rising edge and ≥2 I_clk after it.
- **Read address.** `O_array_map` is held at its last value when `O_rd_buf_en`=0.

## Test plan
- **Identity scaling.** Reset, then frame_start; all buffer entries 0xA5, brightness 255.
  - Each zone's SDI sequence is 1,0,1,0,0,1,0,1 sampled on DCLK rise.
  - LE rises after 90×34 cycles.
  - 4 LE pulses occur per frame.
- **Half scaling.** Gray 0xA5, brightness 127 → 0x52 shifted. Gray 0xFF, brightness 255 → 0xFF. Brightness 0 → all bits 0.
- **Address sequence.** Capture `O_array_map` at each `O_rd_buf_en`.
  - Order is 89..0, 179..90, 269..180, 359..270.
  - Exactly 360 reads, each followed 1 cycle later by a LOAD.
- **Scan and blanking.**
  - `O_scan`=0 for 16 cycles after each LE falls.
  - Then 0001, 0010, 0100, 1000 in order.
  - 1000 persists in IDLE; `O_busy` falls at cycle 12320.
- **Pending frames.** Three frame_start pulses during a frame, plus one coincident with the return to IDLE → exactly one further frame. Brightness changed mid-frame has no effect until the next frame.
- **Reset mid-frame.** Assert `I_rst` during SHIFT of zone 40, scan 2.
  - Next cycle: all outputs 0, no LE pulse, state IDLE.
  - A new frame_start restarts at address 89.

Source files
------------

// File: rtl/led_zone_shifter.sv
// -----------------------------------------------------------------------------
// led_zone_shifter
//
// Reads one frame of SCANS*ZONES zone gray levels from the zone buffer and
// scales each one by a global brightness. It then shifts them MSB first into
// the MiniLED driver chain using the DCLK/SDI/LE protocol, and drives the
// one-hot scan-line enables.
//
// Per zone:  FETCH (1) + LOAD (1) + SHIFT (32)          = 34 cycles
// Per scan:  ZONES zones + LATCH (4) + DEAD (DEAD)
// Zones are sent from ZONES-1 down to 0, so zone 0 is the last one in the chain.
//
// Ports
//   I_clk          system clock (50 MHz)
//   I_rst          synchronous, active-high reset
//   I_frame_start  one-cycle pulse: a new zone frame is ready in the buffer
//   I_brightness   global brightness, captured when a frame starts
//   O_rd_buf_en    buffer read strobe
//   O_array_map    buffer read address; holds its value between reads
//   I_gray_data    buffer read data, valid one cycle after O_rd_buf_en
//   O_DCLK         shift clock, I_clk/4 while shifting, otherwise 0
//   O_SDI          serial data, MSB first
//   O_LE           latch enable, a 4-cycle pulse after each scan line
//   O_scan         one-hot scan-line enable
//   O_busy         a frame is in progress
// -----------------------------------------------------------------------------
module led_zone_shifter #(
  parameter int ZONES = 90,
  parameter int SCANS = 4,
  parameter int DEAD  = 16
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic       I_frame_start,
  input  logic [7:0] I_brightness,
  output logic       O_rd_buf_en,
  output logic [8:0] O_array_map,
  input  logic [7:0] I_gray_data,
  output logic       O_DCLK,
  output logic       O_SDI,
  output logic       O_LE,
  output logic [3:0] O_scan,
  output logic       O_busy
);

  localparam int ZONE_W = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int SCAN_W = (SCANS > 1) ? $clog2(SCANS) : 1;
  localparam int CNT_W  = ($clog2(DEAD) > 5) ? $clog2(DEAD) : 5;

  localparam logic [ZONE_W-1:0] ZONE_LAST  = ZONE_W'(ZONES - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST  = SCAN_W'(SCANS - 1);
  localparam logic [CNT_W-1:0]  SHIFT_LAST = CNT_W'(31);
  localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(3);
  localparam logic [CNT_W-1:0]  DEAD_LAST  = CNT_W'(DEAD - 1);
  localparam logic [8:0]        ZONES_A    = 9'(ZONES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DEAD
  } state_t;

  state_t              state_q, state_d;
  logic                pending_q;
  logic [7:0]          bright_q;
  logic [SCAN_W-1:0]   scan_q;
  logic [ZONE_W-1:0]   zone_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [7:0]          shreg_q;

  logic [8:0]          scan_base;
  logic [16:0]         product;
  logic [7:0]          scaled;

  // The first address of the current scan line in the zone buffer.
  assign scan_base = 9'(scan_q) * ZONES_A;

  // Multiplying by (bright+1) makes 255 an exact identity and keeps 0 dark.
  assign product = 17'(I_gray_data) * (17'(bright_q) + 17'd1);
  assign scaled  = 8'(product >> 8);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: State registers use non-blocking assignments so that every flop
  // samples values from before the edge, whatever order the blocks run in.
  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next state and panel outputs
  // ---------------------------------------------------------------------------
  // NOTE: Every signal driven here gets a default first, so no path through
  // the case can leave a value unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    O_rd_buf_en = 1'b0;
    O_DCLK      = 1'b0;
    O_SDI       = 1'b0;
    O_LE        = 1'b0;
    O_busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        O_busy = 1'b0;
        if (I_frame_start || pending_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        O_rd_buf_en = 1'b1;
        state_d     = ST_LOAD;
      end
      ST_LOAD: state_d = ST_SHIFT;
      ST_SHIFT: begin
        // Bit period = 4 cycles: DCLK low in phases 0-1, high in phases 2-3.
        // SDI changes only at phase 0, so it has two cycles of setup and two
        // of hold around the DCLK rising edge.
        O_DCLK = cnt_q[1];
        O_SDI  = shreg_q[7];
        if (cnt_q == SHIFT_LAST) state_d = (zone_q == '0) ? ST_LATCH : ST_FETCH;
      end
      ST_LATCH: begin
        O_LE = 1'b1;
        if (cnt_q == LATCH_LAST) state_d = ST_DEAD;
      end
      ST_DEAD: begin
        if (cnt_q == DEAD_LAST) state_d = (scan_q == SCAN_LAST) ? ST_IDLE : ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: counters, read address, shift register, scan enables
  // ---------------------------------------------------------------------------
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pending_q   <= 1'b0;
      bright_q    <= '0;
      scan_q      <= '0;
      zone_q      <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      O_array_map <= '0;
      O_scan      <= '0;
    end else begin
      // A start request during a frame is remembered once. It also covers a
      // pulse on the last DEAD cycle, because the state is not yet IDLE then.
      if (I_frame_start && (state_q != ST_IDLE)) pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (I_frame_start || pending_q) begin
            pending_q   <= 1'b0;
            bright_q    <= I_brightness;
            scan_q      <= '0;
            zone_q      <= ZONE_LAST;
            O_array_map <= 9'(ZONE_LAST);
          end
        end
        ST_LOAD: begin
          shreg_q <= scaled;
          cnt_q   <= '0;
        end
        ST_SHIFT: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q[1:0] == 2'd3) shreg_q <= {shreg_q[6:0], 1'b0};
          if (cnt_q == SHIFT_LAST) begin
            cnt_q <= '0;
            if (zone_q != '0) begin
              zone_q      <= zone_q - ZONE_W'(1);
              O_array_map <= scan_base + 9'(zone_q) - 9'd1;
            end
          end
        end
        ST_LATCH: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == LATCH_LAST) begin
            cnt_q  <= '0;
            O_scan <= '0;
          end
        end
        ST_DEAD: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == DEAD_LAST) begin
            cnt_q  <= '0;
            // Show the line that was just latched. It stays on while the
            // next line shifts, and the last line stays on through IDLE.
            O_scan <= 4'b0001 << scan_q;
            if (scan_q != SCAN_LAST) begin
              scan_q      <= scan_q + SCAN_W'(1);
              zone_q      <= ZONE_LAST;
              O_array_map <= scan_base + ZONES_A + 9'(ZONE_LAST);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
